// File: rtl/keypad_to_num.sv
// Keypad digit entry buffer (BCD) with a sequential multiply-by-ten converter to binary.
// Optional build macro KEYPAD_LEADING_ZERO_SUPPRESS_EN: leading zeros are accepted but not stored.
`timescale 1ns/1ps
module keypad_to_num #(
    parameter int DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        backspace,
    input  logic        clear,
    input  logic        enter,
    output logic [15:0] bcd,
    output logic [2:0]  digit_count,
    output logic        busy,
    output logic [13:0] num,
    output logic        num_valid,
    output logic        err
);

    localparam logic [2:0] DIGITS_L = 3'(DIGITS);

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t      state_q;
    logic [15:0] bcd_q;
    logic [2:0]  count_q;
    logic [15:0] shadow_q;
    logic [13:0] acc_q;
    logic [13:0] acc_d;
    logic [2:0]  step_q;
    logic [13:0] num_q;
    logic        busy_q;
    logic        num_valid_q;
    logic        err_q;

    logic [15:0] nib_mask;
    logic        digit_ok;
    logic        room;
    logic        lead_zero;

    // Only the lowest DIGITS nibbles of the buffer and shadow are live.
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
        assign nib_mask[4*gi +: 4] = (gi < DIGITS) ? 4'hF : 4'h0;
    end

    always_comb begin
        digit_ok = (digit <= 4'd9);
        room     = (count_q < DIGITS_L);
`ifdef KEYPAD_LEADING_ZERO_SUPPRESS_EN
        lead_zero = (digit == 4'd0) && (count_q == 3'd0);
`else
        lead_zero = 1'b0;
`endif
        // acc*10 + next nibble, built from shifts to avoid a multiplier
        acc_d = {acc_q[10:0], 3'b000} + {acc_q[12:0], 1'b0}
              + {10'd0, shadow_q[4*DIGITS-1 -: 4]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bcd_q       <= '0;
            count_q     <= '0;
            shadow_q    <= '0;
            acc_q       <= '0;
            step_q      <= '0;
            num_q       <= '0;
            busy_q      <= 1'b0;
            num_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            num_valid_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear) begin
                        bcd_q   <= '0;
                        count_q <= '0;
                    end else if (enter) begin
                        shadow_q <= bcd_q;
                        acc_q    <= '0;
                        step_q   <= '0;
                        bcd_q    <= '0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_CONV;
                    end else if (backspace) begin
                        if (count_q != 3'd0) begin
                            bcd_q   <= bcd_q >> 4;
                            count_q <= count_q - 3'd1;
                        end
                    end else if (digit_valid) begin
                        if (!digit_ok || !room) begin
                            err_q <= 1'b1;
                        end else if (!lead_zero) begin
                            bcd_q   <= ({bcd_q[11:0], digit}) & nib_mask;
                            count_q <= count_q + 3'd1;
                        end
                    end
                end
                S_CONV: begin
                    if (clear) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        shadow_q <= (shadow_q << 4) & nib_mask;
                        step_q   <= step_q + 3'd1;
                        if (step_q == DIGITS_L - 3'd1) begin
                            num_q       <= acc_d;
                            num_valid_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bcd         = bcd_q;
    assign digit_count = count_q;
    assign busy        = busy_q;
    assign num         = num_q;
    assign num_valid   = num_valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_keypad_to_num.sv
// Scoreboard bench for keypad_to_num: stimulus pushes expected num/err events, a monitor pops them.
`timescale 1ns/1ps
module tb_keypad_to_num;

    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        backspace = 1'b0;
    logic        clear = 1'b0;
    logic        enter = 1'b0;
    logic [15:0] bcd;
    logic [2:0]  digit_count;
    logic        busy;
    logic [13:0] num;
    logic        num_valid;
    logic        err;

    keypad_to_num #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
        .backspace(backspace), .clear(clear), .enter(enter), .bcd(bcd),
        .digit_count(digit_count), .busy(busy), .num(num),
        .num_valid(num_valid), .err(err)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [13:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every num_valid / err pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (num_valid) begin
                if (sb.size() == 0) check("unexpected_num_valid", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("event_kind_num", int'(e.is_err), 0);
                    check("num_value", int'(num), int'(e.val));
                    $display("mon num_valid num=%0d", num);
                end
            end
            if (err) begin
                if (sb.size() == 0) check("unexpected_err", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("event_kind_err", int'(e.is_err), 1);
                    $display("mon err");
                end
            end
        end
    end

    task automatic key(input logic [3:0] d, input bit exp_err);
        if (exp_err) sb.push_back('{1'b1, 14'd0});
        digit = d;
        digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
        $display("tx digit %0d bcd=0x%04h count=%0d", d, bcd, digit_count);
    endtask

    task automatic strobe_bs();
        backspace = 1'b1;
        @(negedge clk);
        backspace = 1'b0;
        $display("tx backspace bcd=0x%04h count=%0d", bcd, digit_count);
    endtask

    task automatic strobe_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        $display("tx clear busy=%0d", busy);
    endtask

    task automatic strobe_enter();
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        $display("tx enter busy=%0d", busy);
    endtask

    // Full conversion: expects DIGITS busy cycles, then the queued num event.
    task automatic convert(input int exp_num, input string nm);
        int cnt;
        sb.push_back('{1'b0, 14'(exp_num)});
        strobe_enter();
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        check({nm, "_busy_cycles"}, cnt, DIGITS);
        check({nm, "_bcd_after"}, int'(bcd), 0);
        check({nm, "_count_after"}, int'(digit_count), 0);
        @(negedge clk);
        check({nm, "_num_held"}, int'(num), exp_num);
        check({nm, "_nv_one_cycle"}, int'(num_valid), 0);
    endtask

    initial begin
        int lz_count;
        repeat (3) @(negedge clk);
        check("rst_bcd", int'(bcd), 0);
        check("rst_count", int'(digit_count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_num", int'(num), 0);
        check("rst_nv", int'(num_valid), 0);
        check("rst_err", int'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1,2,5 -> 125
        key(4'd1, 0); key(4'd2, 0); key(4'd5, 0);
        check("t1_bcd", int'(bcd), 'h0125);
        check("t1_count", int'(digit_count), 3);
        convert(125, "t1");

        // 9999 then overflowing fifth digit
        key(4'd9, 0); key(4'd9, 0); key(4'd9, 0); key(4'd9, 0);
        key(4'd7, 1);
        check("t2_bcd", int'(bcd), 'h9999);
        check("t2_count", int'(digit_count), 4);
        convert(9999, "t2");

        // illegal code 12
        key(4'd3, 0);
        key(4'd12, 1);
        check("t3_bcd", int'(bcd), 'h0003);
        check("t3_count", int'(digit_count), 1);
        @(negedge clk);
        check("t3_err_one_cycle", int'(err), 0);
        strobe_clear();
        check("t3_clear_bcd", int'(bcd), 0);
        check("t3_clear_count", int'(digit_count), 0);

        // 4,5,6, backspace, 8 -> 458
        key(4'd4, 0); key(4'd5, 0); key(4'd6, 0);
        strobe_bs();
        check("t4_bs_bcd", int'(bcd), 'h0045);
        key(4'd8, 0);
        check("t4_bcd", int'(bcd), 'h0458);
        check("t4_count", int'(digit_count), 3);
        convert(458, "t4");

        // 3,1 enter, digit during CONV ignored, clear in second CONV cycle aborts
        key(4'd3, 0); key(4'd1, 0);
        strobe_enter();
        check("t5_busy_conv", int'(busy), 1);
        key(4'd6, 0);
        strobe_clear();
        check("t5_busy_after_clear", int'(busy), 0);
        check("t5_num_kept", int'(num), 458);
        check("t5_bcd", int'(bcd), 0);
        check("t5_count", int'(digit_count), 0);
        repeat (5) @(negedge clk);
        check("t5_num_still", int'(num), 458);

        // leading zeros
        key(4'd0, 0); key(4'd0, 0); key(4'd7, 0);
`ifdef KEYPAD_LEADING_ZERO_SUPPRESS_EN
        lz_count = 1;
`else
        lz_count = 3;
`endif
        check("t6_count", int'(digit_count), lz_count);
        check("t6_bcd", int'(bcd), 'h0007);
        convert(7, "t6");

        // backspace on empty buffer, then enter on empty buffer
        strobe_bs();
        check("t7_bs_empty_count", int'(digit_count), 0);
        convert(0, "t7");

        // reset during conversion clears num
        key(4'd5, 0);
        convert(5, "t8");
        key(4'd6, 0);
        strobe_enter();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t9_rst_num", int'(num), 0);
        check("t9_rst_busy", int'(busy), 0);
        check("t9_rst_nv", int'(num_valid), 0);
        $display("tx async reset mid-conversion num=%0d busy=%0d", num, busy);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("t9_num_after", int'(num), 0);
        check("t9_count_after", int'(digit_count), 0);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_to_num.md
# keypad_to_num

- Accepts decimal digits one at a time from the keypad debouncer/scanner.
- Holds up to four of them as a BCD entry buffer, which is echoed to the display.
- On `enter`, converts the buffer to a 14-bit binary number with a sequential multiply-by-ten-and-add loop.
- Inverse of the 7-segment digit split: it produces the binary amount (price/selection code) consumed by the vending controller.

## Interface
Parameters:
- `DIGITS`, 4: entry buffer depth in decimal digits; legal range 1..4.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `digit_valid`  in  1  single-cycle strobe; `digit` is meaningful.
- `digit`  in  4  key code; 0..9 legal, 10..15 illegal.
- `backspace`  in  1  single-cycle strobe; remove the last-entered digit.
- `clear`  in  1  single-cycle strobe; empty the buffer and abort any conversion.
- `enter`  in  1  single-cycle strobe; convert the buffer.
- `bcd`  out  16  entry buffer; ones digit in [3:0]; unused upper nibbles are 0.
- `digit_count`  out  3  number of digits in the buffer, 0..DIGITS.
- `busy`  out  1  high while a conversion runs.
- `num`  out  14  last converted value; held until the next successful conversion.
- `num_valid`  out  1  one-cycle pulse when `num` is updated.
- `err`  out  1  one-cycle pulse when a digit is rejected.

## Operation
- **FSM states:** IDLE and CONV.

**IDLE, per-cycle priority: clear > enter > backspace > digit_valid.**
- `clear`:
  - `bcd` and `digit_count` go to 0.
- `enter`:
  - Copy `bcd` to an internal shadow register, zero the accumulator and the step counter.
  - Clear `bcd` and `digit_count`; go to CONV.
  - An empty buffer is legal and converts to 0.
- `backspace`:
  - If `digit_count` > 0: shift `bcd` right one nibble, zero-fill the top, decrement `digit_count`.
  - If `digit_count` = 0: no effect, no `err`.
- `digit_valid` with `digit` ≤ 9 and `digit_count` < DIGITS:
  - `bcd` = (`bcd` << 4) | `digit`, masked to DIGITS nibbles.
  - Increment `digit_count`.
- `digit_valid` with `digit` > 9, or with `digit_count` = DIGITS:
  - Buffer unchanged; pulse `err`.

**CONV:**
- Each cycle: acc = acc*10 + the most significant remaining shadow nibble.
  - Computed as (acc<<3)+(acc<<1)+nibble in 14 bits.
- The shadow register shifts left one nibble per step; exactly DIGITS steps.
- On the final step the result is written to `num`, `num_valid` pulses, and the FSM returns to IDLE.
- `digit_valid`, `backspace` and `enter` are ignored with no `err`.
- `clear` aborts: return to IDLE with no `num_valid`; `num` keeps its old value.
- Arithmetic never overflows: the maximum value 9999 fits in 14 bits.

## Timing
- Reset values:
  - `bcd`=0, `digit_count`=0, `busy`=0, `num`=0, `num_valid`=0, `err`=0.
  - FSM in IDLE.
- Buffer updates take effect at the sampling edge; `bcd` and `digit_count` are valid the following cycle.
- `err` is registered and high for the cycle after the rejecting edge.
- Conversion latency:
  - `enter` sampled at edge E0; `busy` high from E0 to E(DIGITS).
  - `num` updated and `num_valid` high from edge E(DIGITS) for one cycle.
  - A new `enter` is accepted at E(DIGITS)+1 at the earliest.
- Reset asserted mid-conversion: all outputs return to reset values immediately; `num` is cleared to 0.
- Strobes wider than one cycle are treated as repeated strobes; upstream guarantees single-cycle pulses.

## Configuration
- Macro: `KEYPAD_LEADING_ZERO_SUPPRESS_EN`.
- Defined: `digit_valid` with `digit`=0 while `digit_count`=0 is accepted without `err`, but the buffer and `digit_count` stay 0. Leading zeros do not consume slots.
- Undefined: a leading 0 is stored like any digit and increments `digit_count`.

## Test plan
- Reset, then digits 1,2,5, then `enter`:
  - `bcd`=0x0125 and `digit_count`=3 before enter.
  - `busy` high 4 cycles; `num`=125 with a one-cycle `num_valid`.
  - After enter, `bcd`=0 and `digit_count`=0.
- Digits 9,9,9,9 then 7:
  - The fifth digit pulses `err`; `bcd` stays 0x9999.
  - `enter` gives `num`=9999.
- Digit code 12:
  - `err` pulses; buffer unchanged.
- Digits 4,5,6, `backspace`, digit 8:
  - `bcd`=0x0458, `digit_count`=3.
  - `enter` gives `num`=458.
- `enter` with digits 3,1, then `clear` during the second CONV cycle:
  - No `num_valid`; `num` keeps its previous value; `busy` low next cycle.
  - A digit strobe during CONV is ignored.
- Digits 0,0,7, then `enter`:
  - With `KEYPAD_LEADING_ZERO_SUPPRESS_EN`: `digit_count`=1.
  - Without it: `digit_count`=3.
  - `num`=7 in both builds.
- `enter` on an empty buffer:
  - `num`=0 with `num_valid`, no `err`.
